// File: rtl/mul_issue_stage.sv
// Two-entry issue pipeline wrapping an external signed 32x32 multiplier; fixes up the
// signed product for MULH/MULHSU/MULHU. Define MUL_OVF_DETECT_EN to enable MUL overflow flag.
module mul_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [3:0]  in_tag,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        out_overflow,
  output logic [3:0]  out_tag
);

  typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU} mul_op_e;

  typedef struct packed {
    mul_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
  } req_t;

  typedef struct packed {
    logic [63:0] result;
`ifdef MUL_OVF_DETECT_EN
    logic        ovf;
`endif
    logic [3:0]  tag;
  } rsp_t;

  // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied
  logic [2:1]  vld_pipe;
  req_t        s1_q;
  rsp_t        s2_q, s2_d;
  logic        adv, accept;
  logic [31:0] hi;
  logic [63:0] p;

  assign adv      = !vld_pipe[2] || out_ready;
  assign in_ready = rst_n && (!vld_pipe[1] || adv);
  assign accept   = in_valid && in_ready;

  assign mul_a = s1_q.a;
  assign mul_b = s1_q.b;

  // Unsigned operands are the signed ones plus 2^32 when bit 31 is set; only the
  // upper half of the product needs the cross-term corrections.
  always_comb begin
    hi = mul_product[63:32];
    if ((s1_q.op == OP_MULHSU || s1_q.op == OP_MULHU) && s1_q.b[31]) hi = hi + s1_q.a;
    if (s1_q.op == OP_MULHU && s1_q.a[31]) hi = hi + s1_q.b;
    p = {hi, mul_product[31:0]};
  end

  always_comb begin
    s2_d = '0;
    s2_d.tag = s1_q.tag;
    case (s1_q.op)
      OP_MUL:  s2_d.result = {{32{p[31]}}, p[31:0]};
      OP_MULHU: s2_d.result = {32'b0, p[63:32]};
      default: s2_d.result = {{32{p[63]}}, p[63:32]};
    endcase
`ifdef MUL_OVF_DETECT_EN
    s2_d.ovf = (s1_q.op == OP_MUL) && !((&p[63:31]) || !(|p[63:31]));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (adv) vld_pipe[2] <= vld_pipe[1];
      if (adv && vld_pipe[1]) s2_q <= s2_d;
      if (accept) begin
        vld_pipe[1] <= 1'b1;
        s1_q        <= '{op: mul_op_e'(in_op), a: in_a, b: in_b, tag: in_tag};
      end else if (adv) begin
        vld_pipe[1] <= 1'b0;
      end
    end
  end

  assign out_valid  = vld_pipe[2];
  assign out_result = s2_q.result;
  assign out_tag    = s2_q.tag;
`ifdef MUL_OVF_DETECT_EN
  assign out_overflow = s2_q.ovf;
`else
  assign out_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mul_issue_stage.sv
// Self-checking bench for mul_issue_stage: directed vector table, backpressure and
// reset sequences, then random traffic against a full-width arithmetic reference.
module tb_mul_issue_stage;

`ifdef MUL_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [3:0]  in_tag = '0;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_product;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic        out_overflow;
  logic [3:0]  out_tag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // External multiplier: signed product via sign-extended 64-bit multiply.
  assign mul_product = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};

  mul_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .out_tag(out_tag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: true mathematical product of the operands under each op's signedness.
  typedef struct {
    logic [63:0] res;
    logic        ovf;
    logic [3:0]  tag;
  } exp_t;

  function automatic exp_t ref_calc(input logic [1:0] op, input logic [31:0] a, b,
                                    input logic [3:0] tag);
    exp_t e;
    logic [63:0] sa, sb, ua, ub, full;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    e.tag = tag;
    e.ovf = 1'b0;
    case (op)
      2'd0: begin
        full  = sa * sb;
        e.res = {{32{full[31]}}, full[31:0]};
        e.ovf = OVF_EN && (full != e.res);
      end
      2'd1: begin full = sa * sb; e.res = {{32{full[63]}}, full[63:32]}; end
      2'd2: begin full = sa * ub; e.res = {{32{full[63]}}, full[63:32]}; end
      default: begin full = ua * ub; e.res = {32'b0, full[63:32]}; end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [3:0]  tag;
    logic [63:0] res;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];
  exp_t q[$];
  exp_t e;
  logic        hold_prev;
  logic [63:0] prev_res;
  logic        prev_ovf;
  logic [3:0]  prev_tag;

  initial begin
    vecs[0] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 64'h0000_0000_FFFF_FFFE, 1'b0};
    vecs[1] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[2] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 64'h0,                   1'b0};
    vecs[3] = '{2'd0, 32'h0001_0000, 32'h0001_0000, 4'd5, 64'h0,                   1'b1};
    vecs[4] = '{2'd0, 32'h0000_0003, 32'hFFFF_FFFE, 4'd6, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0};
    vecs[5] = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 64'hFFFF_FFFF_8000_0000, 1'b1};
    vecs[6] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 4'd8, 64'h0000_0000_4000_0000, 1'b0};
    vecs[7] = '{2'd3, 32'h8000_0000, 32'h0000_0002, 4'd9, 64'h0000_0000_0000_0001, 1'b0};
    vecs[8] = '{2'd2, 32'h8000_0000, 32'h0000_0002, 4'hA, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[9] = '{2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 4'hB, 64'h0000_0000_7FFF_FFFF, 1'b0};

    // Reset state
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_ovf", out_overflow, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);

    // Directed vector table, each checked for 2-cycle latency
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b;
      in_tag = vecs[i].tag; out_ready = 1'b1;
      #1 chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk($sformatf("vec%0d_early_valid", i), out_valid, 0);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_result", i), out_result, vecs[i].res);
      chk($sformatf("vec%0d_ovf", i), out_overflow, vecs[i].ovf & OVF_EN);
      chk($sformatf("vec%0d_tag", i), out_tag, vecs[i].tag);
    end
    @(negedge clk);

    // Backpressure: three offered, two accepted, output frozen on tag 1
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_a = 32'd3; in_b = 32'd1; in_tag = 4'd1;
    @(negedge clk);
    in_a = 32'd5; in_tag = 4'd2;
    @(negedge clk);
    in_a = 32'd7; in_tag = 4'd3;
    #1;
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_tag1", out_tag, 1);
    @(negedge clk);
    #1;
    chk("bp_hold_tag", out_tag, 1);
    chk("bp_hold_result", out_result, 64'd3);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_drain_tag2", out_tag, 2);
    chk("bp_drain_res2", out_result, 64'd5);
    @(negedge clk);
    #1;
    chk("bp_drain_tag3", out_tag, 3);
    chk("bp_drain_res3", out_result, 64'd7);
    @(negedge clk);
    #1 chk("bp_empty", out_valid, 0);

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_a = 32'h1234; in_b = 32'h10; in_tag = 4'd7;
    @(negedge clk);
    in_tag = 4'd8;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("mr_full_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 0);
    chk("mr_out_tag", out_tag, 0);
    chk("mr_out_result", out_result, 0);
    chk("mr_mul_a", mul_a, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("mr_release_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("mr_no_stale", out_valid, 0);
    end

    // Random traffic vs. reference queue
    hold_prev = 1'b0;
    prev_res = '0; prev_ovf = 1'b0; prev_tag = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (hold_prev) begin
        chk("rnd_hold_result", out_result, prev_res);
        chk("rnd_hold_tag", out_tag, prev_tag);
        chk("rnd_hold_ovf", out_overflow, prev_ovf);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_a      = pick();
      in_b      = pick();
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd_unexpected_out actual=tag%0d required=none", out_tag);
        end else begin
          e = q.pop_front();
          chk("rnd_result", out_result, e.res);
          chk("rnd_ovf", out_overflow, e.ovf);
          chk("rnd_tag", out_tag, e.tag);
        end
      end
      if (in_valid && in_ready) q.push_back(ref_calc(in_op, in_a, in_b, in_tag));
      hold_prev = out_valid && !out_ready;
      prev_res = out_result; prev_ovf = out_overflow; prev_tag = out_tag;
    end

    // Drain with bounded wait
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && q.size() > 0; cyc++) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        chk("drain_result", out_result, e.res);
        chk("drain_ovf", out_overflow, e.ovf);
        chk("drain_tag", out_tag, e.tag);
      end
      @(negedge clk);
    end
    chk("drain_left", 64'(q.size()), 0);
    #1 chk("drain_idle", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
